// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: responder state encoding and user BRAM memory map shared with the DMA
package wb_bram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
  localparam logic [31:0] USER_BRAM_BASE = 32'h3800_0000;
  localparam logic [31:0] FIR_TAP_OFF = 32'h0000_0100;
  localparam logic [31:0] FIR_DATA_OFF = 32'h0000_02b0;
  localparam logic [31:0] FIR_RESULT_OFF = 32'h0000_02b4;
endpackage

// File: rtl/sp_bram_bytewe.sv
// sp_bram_bytewe: single-port synchronous RAM with byte-lane write enables and registered read
module sp_bram_bytewe #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    sel_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++)
        if (we_i && sel_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      if (!we_i) rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/wb_bram_responder.sv
// wb_bram_responder: Wishbone classic slave fronting a byte-writable BRAM with fixed access latency
module wb_bram_responder
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = USER_BRAM_BASE,
  parameter int DEPTH = 1024,
  parameter int DELAYS = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DELAYS) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic we_q, we_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [29:0] off;
  logic [31:0] rdata;
  logic hit, start, last, commit, unused_adr;
  assign off = wbs_adr_i[31:2] - BASE_ADDR[31:2];
  assign hit = wbs_cyc_i && wbs_stb_i && (off < 30'(DEPTH));
  assign start = (state_q == IDLE) && hit;
  assign last = cnt_q == CW'(DELAYS - 1);
  assign commit = (state_q == WAIT) && wbs_cyc_i && last;
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = hit ? WAIT : IDLE;
      WAIT: state_d = !wbs_cyc_i ? IDLE : (last ? ACK : WAIT);
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    idx_d = start ? off[AW-1:0] : idx_q;
    we_d = start ? wbs_we_i : we_q;
    sel_d = start ? wbs_sel_i : sel_q;
    dat_d = start ? wbs_dat_i : dat_q;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      we_q <= we_d;
      sel_q <= sel_d;
      dat_q <= dat_d;
    end
  end
  sp_bram_bytewe #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i(wb_clk_i),
    .en_i(commit),
    .we_i(we_q),
    .sel_i(sel_q),
    .addr_i(idx_q),
    .wdata_i(dat_q),
    .rdata_o(rdata)
  );
  assign wbs_ack_o = state_q == ACK;
  assign busy_o = state_q != IDLE;
  assign wbs_dat_o = (wbs_ack_o && !we_q) ? rdata : '0;
endmodule

// File: tb/tb_wb_bram_responder.sv
// tb_wb_bram_responder: randomized scoreboard bench for wb_bram_responder against a word-array model
module tb_wb_bram_responder;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int DEPTH = 1024;
  localparam int DELAYS = 10;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat_i = 0;
  logic ack, busy;
  logic [31:0] dat_o;
  typedef struct {bit rd; logic [31:0] data; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] model [DEPTH];
  bit valid [DEPTH];
  int vectors = 0, miscompares = 0, cyc_n = 0;
  wb_bram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DELAYS(DELAYS)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack=1 at edge %0d required no ack", cyc_n + 1);
      end else begin
        e = sb.pop_front();
        check("ack_latency", cyc_n + 1, e.due);
        if (e.rd) check("read_data", dat_o, e.data);
      end
    end
  end
  function automatic int widx(logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  task automatic drive(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, output int n);
    @(posedge clk);
    #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    n = cyc_n + 1;
  endtask
  task automatic expect_txn(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, int n);
    int i;
    logic [31:0] m;
    i = widx(a);
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (w) begin
      model[i] = (model[i] & ~m) | (d & m);
      valid[i] = 1;
      sb.push_back('{rd: 1'b0, data: 32'h0, due: n + DELAYS + 1});
    end else sb.push_back('{rd: 1'b1, data: model[i], due: n + DELAYS + 1});
  endtask
  task automatic wait_ack(string name);
    bit got;
    got = 0;
    for (int k = 0; k < DELAYS + 4 && !got; k++) begin
      @(negedge clk);
      got = ack;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s: got no ack within %0d cycles required ack", name, DELAYS + 4);
    end
  endtask
  task automatic xfer(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int n;
    drive(w, a, d, s, n);
    expect_txn(w, a, d, s, n);
    wait_ack("xfer_ack");
    @(posedge clk);
    #1;
    cyc = 0; stb = 0;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 0);
    check("dat_after_ack", dat_o, 0);
  endtask
  task automatic stream(logic [31:0] a0, int cnt);
    int n0;
    drive(0, a0, 0, 0, n0);
    for (int k = 0; k < cnt; k++) begin
      expect_txn(0, a0 + 4 * k, 0, 0, n0 + k * (DELAYS + 2));
      wait_ack("stream_ack");
      @(posedge clk);
      #1;
      adr = a0 + 4 * (k + 1);
      if (k == cnt - 1) begin cyc = 0; stb = 0; end
      @(negedge clk);
      check("stream_ack_drop", 32'(ack), 0);
    end
  endtask
  task automatic no_ack(logic [31:0] a, int cycles);
    int n;
    bit bad_ack, bad_busy;
    bad_ack = 0; bad_busy = 0;
    drive(1, a, 32'hCAFE_F00D, 4'hF, n);
    repeat (cycles) begin
      @(negedge clk);
      if (ack) bad_ack = 1;
      if (busy) bad_busy = 1;
    end
    check("oor_ack", 32'(bad_ack), 0);
    check("oor_busy", 32'(bad_busy), 0);
    @(posedge clk);
    #1;
    cyc = 0; stb = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, idx;
    bit w, bad_ack;
    logic [3:0] s;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", 32'(busy), 0);
    #2 rst_n = 1;
    xfer(1, BASE + 32'h100, 32'hDEAD_BEEF, 4'hF);
    xfer(0, BASE + 32'h100, 0, 0);
    xfer(1, BASE + 32'h104, 32'h1122_3344, 4'hF);
    xfer(1, BASE + 32'h104, 32'hAABB_CCDD, 4'b0101);
    xfer(0, BASE + 32'h104, 0, 0);
    xfer(1, BASE + 32'h104, 32'hFFFF_FFFF, 4'h0);
    xfer(0, BASE + 32'h105, 0, 0);
    for (int k = 0; k < 11; k++) xfer(1, BASE + 32'h100 + 4 * k, $urandom, 4'hF);
    stream(BASE + 32'h100, 11);
    xfer(1, BASE, 32'h0102_0304, 4'hF);
    xfer(1, BASE + 4 * (DEPTH - 1), 32'hA5A5_5A5A, 4'hF);
    no_ack(BASE + 4 * DEPTH, 50);
    no_ack(BASE - 4, 20);
    xfer(0, BASE, 0, 0);
    xfer(0, BASE + 4 * (DEPTH - 1), 0, 0);
    xfer(1, BASE + 32'h200, 32'h1234_5678, 4'hF);
    drive(1, BASE + 32'h200, 32'h0BAD_F00D, 4'hF, n);
    repeat (5) @(posedge clk);
    #1;
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    bad_ack = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack) bad_ack = 1;
    end
    check("abort_ack", 32'(bad_ack), 0);
    xfer(0, BASE + 32'h200, 0, 0);
    drive(0, BASE + 32'h200, 0, 0, n);
    expect_txn(0, BASE + 32'h200, 0, 0, n);
    wait_ack("ack_before_rst");
    #1 rst_n = 0;
    #1;
    check("rst_in_ack_ack", 32'(ack), 0);
    check("rst_in_ack_dat", dat_o, 0);
    check("rst_in_ack_busy", 32'(busy), 0);
    cyc = 0; stb = 0;
    @(posedge clk);
    #2 rst_n = 1;
    drive(1, BASE + 32'h108, 32'hFFFF_0000, 4'hF, n);
    repeat (4) @(posedge clk);
    #2;
    check("wait_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    check("rst_in_wait_busy", 32'(busy), 0);
    check("rst_in_wait_ack", 32'(ack), 0);
    check("rst_in_wait_dat", dat_o, 0);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    xfer(0, BASE + 32'h108, 0, 0);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: idx = 0;
        1: idx = DEPTH - 1;
        default: idx = $urandom_range(192, 223);
      endcase
      w = !valid[idx] || ($urandom_range(0, 1) == 1);
      s = valid[idx] ? 4'($urandom_range(0, 15)) : 4'hF;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      xfer(w, BASE + 4 * idx + $urandom_range(0, 3), $urandom, s);
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
